// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes 2/3-byte commands from a UART byte stream into
// trigger-level, vector-control and trigger-enable registers, and answers
// each completed command with a single ACK or NAK byte.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a header byte (53 trig, A5 vctr, 5C enable)
// GET_CH  | waiting for the channel index byte
// GET_VAL | waiting for the value byte; applies the command on accept
// RESP    | holding tx_valid/tx_data until the transmitter takes the byte
module uart_cmd_parser #(
  parameter int          TIMEOUT_CYC = 12000,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [7:0] trigout_ch0,
  output logic [7:0] trigout_ch1,
  output logic [7:0] trigout_ch2,
  output logic [7:0] trigout_ch3,
  output logic [7:0] vctrout_ch0,
  output logic [7:0] vctrout_ch1,
  output logic [7:0] vctrout_ch2,
  output logic [7:0] vctrout_ch3,
  output logic       trig_en,
  output logic       busy,
  output logic       cmd_done,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GET_CH  = 2'd1;
  localparam logic [1:0] GET_VAL = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [7:0] HDR_TRIG = 8'h53;
  localparam logic [7:0] HDR_VCTR = 8'hA5;
  localparam logic [7:0] HDR_EN   = 8'h5C;

  localparam logic [1:0] CMD_TRIG = 2'd0;
  localparam logic [1:0] CMD_VCTR = 2'd1;
  localparam logic [1:0] CMD_EN   = 2'd2;

  // A width of at least one bit keeps degenerate TIMEOUT_CYC values legal.
  localparam int          TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [7:0]      ch_q, ch_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0][7:0] trig_q, trig_d;
  logic [3:0][7:0] vctr_q, vctr_d;
  logic            trig_en_q, trig_en_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            cmd_done_q, cmd_done_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            err_inc;

  // Next-state, register-update and error-event decode.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ch_d       = ch_q;
    tmo_d      = '0;
    trig_d     = trig_q;
    vctr_d     = vctr_q;
    trig_en_d  = trig_en_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cmd_done_d = 1'b0;
    err_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_err) begin
          err_inc = 1'b1;
        end else if (rx_valid) begin
          case (rx_data)
            HDR_TRIG: begin cmd_d = CMD_TRIG; state_d = GET_CH; end
            HDR_VCTR: begin cmd_d = CMD_VCTR; state_d = GET_CH; end
            HDR_EN:   begin cmd_d = CMD_EN; ch_d = 8'h00; state_d = GET_VAL; end
            default:  err_inc = 1'b1;
          endcase
        end
      end

      GET_CH: begin
        if (rx_err) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (rx_valid) begin
          ch_d    = rx_data;
          state_d = GET_VAL;
        end else if (tmo_q == TMO_LAST) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      GET_VAL: begin
        if (rx_err) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (rx_valid) begin
          state_d    = RESP;
          tx_valid_d = 1'b1;
          if (cmd_q == CMD_EN) begin
            trig_en_d  = rx_data[0];
            tx_data_d  = ACK_BYTE;
            cmd_done_d = 1'b1;
          end else if (ch_q[7:2] != 6'd0) begin
            tx_data_d = NAK_BYTE;
            err_inc   = 1'b1;
          end else begin
            if (cmd_q == CMD_TRIG) trig_d[ch_q[1:0]] = rx_data;
            else                   vctr_d[ch_q[1:0]] = rx_data;
            tx_data_d  = ACK_BYTE;
            cmd_done_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        // RESP: bytes are dropped; line errors do not disturb the response.
        if (rx_valid) err_inc = 1'b1;
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
    endcase

    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_TRIG;
      ch_q       <= 8'h00;
      tmo_q      <= '0;
      trig_q     <= '0;
      vctr_q     <= '0;
      trig_en_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_done_q <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ch_q       <= ch_d;
      tmo_q      <= tmo_d;
      trig_q     <= trig_d;
      vctr_q     <= vctr_d;
      trig_en_q  <= trig_en_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_done_q <= cmd_done_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign trigout_ch0 = trig_q[0];
  assign trigout_ch1 = trig_q[1];
  assign trigout_ch2 = trig_q[2];
  assign trigout_ch3 = trig_q[3];
  assign vctrout_ch0 = vctr_q[0];
  assign vctrout_ch1 = vctr_q[1];
  assign vctrout_ch2 = vctr_q[2];
  assign vctrout_ch3 = vctr_q[3];
  assign trig_en     = trig_en_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign cmd_done    = cmd_done_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 12000, inter-byte timeout in clk cycles (1 ms at 12 MHz).
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06, response byte for an accepted command.
REQ-003 SHALL have parameter NAK_BYTE, default 8'h15, response byte for a rejected command.
REQ-004 SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-005 SHALL have ports as follows:
- clk  in  1  system clock, 12 MHz
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid when high
- rx_err  in  1  one-cycle framing-error strobe from the receiver
- tx_ready  in  1  UART transmitter can accept a byte
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid
- trigout_ch0..trigout_ch3  out  8 each  trigger level registers
- vctrout_ch0..vctrout_ch3  out  8 each  vector control registers
- trig_en  out  1  global trigger enable
- busy  out  1  high whenever the state is not IDLE
- cmd_done  out  1  one-cycle strobe when a command is applied
- err_cnt  out  8  saturating error counter

Function
REQ-006 SHALL implement the states IDLE, GET_CH, GET_VAL and RESP.
REQ-007 In IDLE, an rx_valid byte SHALL be treated as a header.
- 8'h53: set trigger; go to GET_CH.
- 8'hA5: set vctr; go to GET_CH.
- 8'h5C: enable; go to GET_VAL.
- Any other value: discard, stay in IDLE, err_cnt +1.
REQ-008 In GET_CH, a byte SHALL be latched as the channel index, then the state SHALL move to GET_VAL.
REQ-009 In GET_VAL, the byte SHALL be the value; on the clock edge that accepts it:
- 53: trigout_ch[ch] <= value.
- A5: vctrout_ch[ch] <= value.
- 5C: trig_en <= value[0].
- Then go to RESP.
REQ-010 A channel index greater than 3 SHALL leave all registers unchanged and respond with NAK_BYTE.
REQ-011 A bad channel index SHALL increment err_cnt when the value byte is accepted.
REQ-012 A valid command SHALL respond with ACK_BYTE.
REQ-013 A valid command SHALL pulse cmd_done for exactly one cycle, in the first RESP cycle.
REQ-014 Register updates, tx_data and tx_valid SHALL become visible in the cycle after the rx_valid of the final byte (latency 1).
REQ-015 In RESP, tx_valid SHALL be held high with tx_data stable until a cycle where tx_valid and tx_ready are both high.
REQ-016 After that transfer cycle, the state SHALL be IDLE and tx_valid SHALL be low.
REQ-017 A byte arriving in RESP SHALL be dropped and increment err_cnt; the response SHALL not be affected.
REQ-018 The timeout counter SHALL clear on every rx_valid and on entry to GET_CH or GET_VAL.
REQ-019 In GET_CH or GET_VAL, if the counter reaches TIMEOUT_CYC-1 without a byte:
- Abort to IDLE.
- err_cnt +1.
- No register changes and no response.
REQ-020 An rx_err in any state other than RESP SHALL abort to IDLE with err_cnt +1.
REQ-021 If rx_err and rx_valid occur in the same cycle, rx_err SHALL win and the byte SHALL be discarded.
REQ-022 err_cnt SHALL saturate at 8'hFF.
REQ-023 When two error sources occur in one cycle, err_cnt SHALL increment once.
REQ-024 The timeout counter SHALL be sized by $clog2(TIMEOUT_CYC) and SHALL not wrap while waiting.

Reset
REQ-025 On rst high at a clock edge, the block SHALL enter IDLE and drive all outputs to 0: trigout_*, vctrout_*, trig_en, tx_data, tx_valid, busy, cmd_done, err_cnt.
REQ-026 Reset SHALL take priority over all other events, including a pending tx_valid in RESP; the pending response SHALL be discarded.
REQ-027 After rst deasserts, the first rx_valid byte SHALL be decoded as a header.

Verification
REQ-028 Send 5C,00 then 5C,01 with tx_ready=1 -> trig_en 0 then 1; two ACK bytes (06); cmd_done pulses twice; err_cnt=0.
REQ-029 Send 53,01,7F then A5,03,CC -> trigout_ch1=7F and vctrout_ch3=CC one cycle after the last byte; all other channels stay 00.
REQ-030 Send 53,04,55 -> no register changes; tx_data=15; err_cnt=1.
REQ-031 Send 53,02 then idle for TIMEOUT_CYC cycles, then 00 -> abort to IDLE with err_cnt=1; the 00 is rejected as a header, giving err_cnt=2; no tx_valid.
REQ-032 Send A5,00,11 with tx_ready=0 for 50 cycles and a byte 33 arriving during the wait -> tx_valid=1 and tx_data=06 held stable; err_cnt=1; IDLE one cycle after tx_ready rises.
REQ-033 Assert rst while in RESP, and separately assert rx_err together with rx_valid in GET_VAL -> respectively all outputs 0; abort with err_cnt +1 and registers unchanged.
